// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - requester and divider signals of the shared-divider arbiter
interface div_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [WIDTH-1:0]      res_q;
  logic [WIDTH-1:0]      res_r;
  logic                  res_err;
  logic                  div_start;
  logic [WIDTH-1:0]      div_a;
  logic [WIDTH-1:0]      div_b;
  logic                  div_ready;
  logic                  div_valid;
  logic [WIDTH-1:0]      div_q;
  logic [WIDTH-1:0]      div_r;

  modport slave (
    input  req, a_in, b_in, div_ready, div_valid, div_q, div_r,
    output gnt, done, res_q, res_r, res_err, div_start, div_a, div_b
  );

  modport master (
    output req, a_in, b_in, div_ready, div_valid, div_q, div_r,
    input  gnt, done, res_q, res_r, res_err, div_start, div_a, div_b
  );
endinterface

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one iterative divider among NREQ requesters
// Optional DIV_ZERO_BYPASS_EN answers b==0 locally without starting the divider.
module div_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  div_share_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT) + 1;
`ifdef DIV_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, win, sel, cand;
  logic             found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [NREQ-1:0]  sel_hot;
  logic [TW-1:0]    tmo;
  logic [1:0]       bcnt;
  logic             verr;

  // First requesting index at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_a   = bus.a_in[int'(sel)*WIDTH +: WIDTH];
  assign sel_b   = bus.b_in[int'(sel)*WIDTH +: WIDTH];
  assign sel_hot = {{(NREQ-1){1'b0}}, 1'b1} << sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (found && bus.div_ready)
                   state_nxt = (BYPASS && sel_b == '0) ? RESPOND : LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!bus.div_ready)        state_nxt = WAIT_DONE;
                 else if (bcnt == 2'd3)     state_nxt = RESPOND;
      WAIT_DONE: if (bus.div_ready || tmo == TW'(TIMEOUT-1)) state_nxt = RESPOND;
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // done is raised on entry to RESPOND so it is high exactly during RESPOND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.div_start <= 1'b0;
      bus.div_a     <= '0;
      bus.div_b     <= '0;
      bus.res_q     <= '0;
      bus.res_r     <= '0;
      bus.res_err   <= 1'b0;
      ptr           <= '0;
      win           <= '0;
      tmo           <= '0;
      bcnt          <= '0;
      verr          <= 1'b0;
    end else begin
      bus.div_start <= 1'b0;
      bus.done      <= '0;
      case (state)
        IDLE: if (state_nxt != IDLE) begin
          bus.gnt   <= sel_hot;
          win       <= sel;
          bus.div_a <= sel_a;
          bus.div_b <= sel_b;
          if (state_nxt == RESPOND) begin
            bus.res_q   <= '1;
            bus.res_r   <= sel_a;
            bus.res_err <= 1'b1;
            bus.done    <= sel_hot;
          end else begin
            bus.div_start <= 1'b1;
          end
        end
        LAUNCH: begin
          tmo  <= '0;
          bcnt <= '0;
        end
        WAIT_BUSY: begin
          if (!bus.div_ready) begin
            verr <= ~bus.div_valid;
          end else if (bcnt == 2'd3) begin
            bus.res_q   <= '0;
            bus.res_r   <= '0;
            bus.res_err <= 1'b1;
            bus.done    <= bus.gnt;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end
        WAIT_DONE: begin
          tmo <= tmo + 1'b1;
          if (bus.div_ready) begin
            bus.res_q   <= bus.div_q;
            bus.res_r   <= bus.div_r;
            bus.res_err <= verr;
            bus.done    <= bus.gnt;
          end else if (tmo == TW'(TIMEOUT-1)) begin
            bus.res_q   <= '0;
            bus.res_r   <= '0;
            bus.res_err <= 1'b1;
            bus.done    <= bus.gnt;
          end
        end
        RESPOND: begin
          bus.gnt <= '0;
          ptr     <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
